// File: rtl/usb1bd_rx_pkt_buf.sv
// rtl/usb1bd_rx_pkt_buf.sv - receive packet buffer with commit/rollback on the CRC16 verdict
// Bytes are written speculatively ahead of cmt_ptr; the reader only ever sees committed packets.
module usb1bd_rx_pkt_buf #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_fifo_data,
  input  logic          rx_fifo_dvalid,
  input  logic          rx_fifo_ddone,
  input  logic          crc16_err,
  input  logic          flush,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_last,
  output logic          rd_valid,
  output logic [AW:0]   pkt_cnt,
  output logic          pkt_ok,
  output logic          pkt_drop,
  output logic          rx_zlp
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] P_ONE   = (AW+1)'(1);
  localparam logic [AW:0] P_TWO   = (AW+1)'(2);
  localparam logic [AW:0] P_ROOM2 = (AW+1)'(DEPTH - 2);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RECV  = 2'd1;
  localparam logic [1:0]  S_OVF   = 2'd2;

  logic [8:0]  r_mem [DEPTH];
  logic [1:0]  r_state, w_state_nx;
  logic [AW:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr, r_pkt_cnt;
  logic [AW:0] w_wr_nx, w_cmt_nx, w_used, w_wr_p1;
  logic [7:0]  r_pend, w_pend_nx;
  logic        r_pkt_ok, r_pkt_drop, r_rx_zlp;
  logic        w_full, w_room2, w_commit, w_drop, w_zlp, w_pop, w_pop_eop;
  logic        w_we0, w_we1;
  logic [8:0]  w_wd0, w_wd1, w_rd_ent;

  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign w_full    = w_used[AW];
  assign w_room2   = (w_used <= P_ROOM2);
  assign w_wr_p1   = r_wr_ptr + P_ONE;
  assign w_rd_ent  = r_mem[r_rd_ptr[AW-1:0]];
  assign rd_data   = w_rd_ent[7:0];
  assign rd_last   = w_rd_ent[8];
  assign rd_valid  = (r_rd_ptr != r_cmt_ptr);
  assign w_pop     = rd_en && rd_valid;
  assign w_pop_eop = w_pop && w_rd_ent[8];
  assign pkt_cnt   = r_pkt_cnt;
  assign pkt_ok    = r_pkt_ok;
  assign pkt_drop  = r_pkt_drop;
  assign rx_zlp    = r_rx_zlp;

  always_comb begin
    w_state_nx = r_state;
    w_wr_nx    = r_wr_ptr;
    w_cmt_nx   = r_cmt_ptr;
    w_pend_nx  = r_pend;
    w_we0      = 1'b0;
    w_we1      = 1'b0;
    w_wd0      = '0;
    w_wd1      = '0;
    w_commit   = 1'b0;
    w_drop     = 1'b0;
    w_zlp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_fifo_ddone) begin
          if (!rx_fifo_dvalid) begin
            w_zlp = 1'b1;
          end else if (!crc16_err && !w_full) begin
            w_we0    = 1'b1;
            w_wd0    = {1'b1, rx_fifo_data};
            w_wr_nx  = w_wr_p1;
            w_commit = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (rx_fifo_dvalid) begin
          w_pend_nx  = rx_fifo_data;
          w_state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_fifo_ddone) begin
          if (crc16_err) begin
            w_drop = 1'b1;
          end else if (rx_fifo_dvalid) begin
            // Coincident final byte: pending and final both land this cycle.
            if (w_room2) begin
              w_we0    = 1'b1;
              w_wd0    = {1'b0, r_pend};
              w_we1    = 1'b1;
              w_wd1    = {1'b1, rx_fifo_data};
              w_wr_nx  = r_wr_ptr + P_TWO;
              w_commit = 1'b1;
            end else begin
              w_drop = 1'b1;
            end
          end else if (!w_full) begin
            w_we0    = 1'b1;
            w_wd0    = {1'b1, r_pend};
            w_wr_nx  = w_wr_p1;
            w_commit = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end else if (rx_fifo_dvalid) begin
          if (w_full) begin
            w_state_nx = S_OVF;
          end else begin
            w_we0     = 1'b1;
            w_wd0     = {1'b0, r_pend};
            w_wr_nx   = w_wr_p1;
            w_pend_nx = rx_fifo_data;
          end
        end
      end
      default: begin
        if (rx_fifo_ddone) w_drop = 1'b1;
      end
    endcase
    if (w_commit) begin
      w_cmt_nx   = w_wr_nx;
      w_state_nx = S_IDLE;
    end
    if (w_drop) begin
      w_wr_nx    = r_cmt_ptr;
      w_state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we0 && !flush) r_mem[r_wr_ptr[AW-1:0]] <= w_wd0;
    if (w_we1 && !flush) r_mem[w_wr_p1[AW-1:0]]  <= w_wd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_pend     <= '0;
      r_pkt_cnt  <= '0;
      r_pkt_ok   <= 1'b0;
      r_pkt_drop <= 1'b0;
      r_rx_zlp   <= 1'b0;
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_pend     <= '0;
      r_pkt_cnt  <= '0;
      r_pkt_ok   <= 1'b0;
      r_pkt_drop <= 1'b0;
      r_rx_zlp   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_wr_ptr   <= w_wr_nx;
      r_cmt_ptr  <= w_cmt_nx;
      r_pend     <= w_pend_nx;
      r_pkt_ok   <= w_commit;
      r_pkt_drop <= w_drop;
      r_rx_zlp   <= w_zlp;
      if (w_pop) r_rd_ptr <= r_rd_ptr + P_ONE;
      if (w_commit && !w_pop_eop)      r_pkt_cnt <= r_pkt_cnt + P_ONE;
      else if (!w_commit && w_pop_eop) r_pkt_cnt <= r_pkt_cnt - P_ONE;
    end
  end
endmodule

// File: tb/tb_usb1bd_rx_pkt_buf.sv
// tb/tb_usb1bd_rx_pkt_buf.sv - self-checking bench for usb1bd_rx_pkt_buf
// Directed vector table, corner sequences, then random traffic against a queue model.
module tb_usb1bd_rx_pkt_buf;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_fifo_data = '0;
  logic        rx_fifo_dvalid = 1'b0;
  logic        rx_fifo_ddone = 1'b0;
  logic        crc16_err = 1'b0;
  logic        flush = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic [AW:0] pkt_cnt;
  logic        pkt_ok;
  logic        pkt_drop;
  logic        rx_zlp;

  always #5 clk = ~clk;

  usb1bd_rx_pkt_buf #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_fifo_data(rx_fifo_data), .rx_fifo_dvalid(rx_fifo_dvalid),
    .rx_fifo_ddone(rx_fifo_ddone), .crc16_err(crc16_err), .flush(flush), .rd_en(rd_en),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .pkt_cnt(pkt_cnt),
    .pkt_ok(pkt_ok), .pkt_drop(pkt_drop), .rx_zlp(rx_zlp)
  );

  typedef struct {
    int       len;
    logic [7:0] base;
    logic [7:0] step;
    bit       crc;
    bit       coinc;
    bit       drain;
    bit       ok;
    bit       drop;
    bit       zlp;
    int       cnt;
    bit       valid;
  } vec_t;

  vec_t       vecs[10];
  int         total = 0;
  int         bad = 0;
  logic [8:0] mq[$];
  logic [7:0] pkt_q[$];
  int         mcnt = 0;
  bit         e_ok, e_drop, e_zlp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Packet fits only if every byte finds a free slot: len <= DEPTH - unread committed bytes.
  task automatic model_ddone(input int len, input bit crc);
    e_ok = 0; e_drop = 0; e_zlp = 0;
    if (len == 0) begin
      e_zlp = 1;
    end else if (!crc && len <= DEPTH - mq.size()) begin
      for (int i = 0; i < len; i++) mq.push_back({(i == len - 1), pkt_q[i]});
      mcnt++;
      e_ok = 1;
    end else begin
      e_drop = 1;
    end
  endtask

  task automatic send_pkt(input int len, input bit crc, input bit coinc, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        crc16_err = 1'($urandom);
        tick();
      end
      rx_fifo_data   = pkt_q[i];
      rx_fifo_dvalid = 1'b1;
      crc16_err      = 1'($urandom);
      if (coinc && i == len - 1) begin
        rx_fifo_ddone = 1'b1;
        crc16_err     = crc;
      end
      if (rx_fifo_ddone) model_ddone(len, crc);
      tick();
      rx_fifo_dvalid = 1'b0;
      rx_fifo_ddone  = 1'b0;
      crc16_err      = 1'b0;
    end
    if (!(coinc && len > 0)) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      rx_fifo_ddone = 1'b1;
      crc16_err     = crc;
      model_ddone(len, crc);
      tick();
      rx_fifo_ddone = 1'b0;
      crc16_err     = 1'b0;
    end
  endtask

  task automatic check_status(input string nm);
    chk({nm, "_ok"},    32'(pkt_ok),   32'(e_ok));
    chk({nm, "_drop"},  32'(pkt_drop), 32'(e_drop));
    chk({nm, "_zlp"},   32'(rx_zlp),   32'(e_zlp));
    chk({nm, "_cnt"},   32'(pkt_cnt),  32'(mcnt));
    chk({nm, "_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
  endtask

  task automatic pop_chk();
    bit had;
    had = (mq.size() != 0);
    chk("rd_valid", 32'(rd_valid), 32'(had));
    if (had) begin
      chk("rd_data", 32'(rd_data), 32'(mq[0][7:0]));
      chk("rd_last", 32'(rd_last), 32'(mq[0][8]));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (had) begin
      if (mq[0][8]) mcnt--;
      void'(mq.pop_front());
    end
    chk("rd_cnt", 32'(pkt_cnt), 32'(mcnt));
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 4 && mq.size() > 0; k++) pop_chk();
    chk("drain_valid", 32'(rd_valid), 32'd0);
    chk("drain_cnt",   32'(pkt_cnt),  32'd0);
  endtask

  initial begin
    vecs[0] = '{3,  8'h11, 8'h11, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[1] = '{2,  8'hA0, 8'h01, 0, 0, 0, 1, 0, 0, 1, 1};
    vecs[2] = '{4,  8'hB0, 8'h01, 1, 0, 1, 0, 1, 0, 1, 1};
    vecs[3] = '{0,  8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[4] = '{70, 8'h00, 8'h01, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[5] = '{64, 8'h40, 8'h03, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[6] = '{1,  8'h77, 8'h00, 0, 1, 0, 1, 0, 0, 1, 1};
    vecs[7] = '{63, 8'h10, 8'h05, 0, 1, 0, 1, 0, 0, 2, 1};
    vecs[8] = '{1,  8'h99, 8'h00, 0, 0, 1, 0, 1, 0, 2, 1};
    vecs[9] = '{2,  8'h55, 8'h01, 0, 1, 1, 1, 0, 0, 1, 1};

    repeat (3) tick();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_cnt",   32'(pkt_cnt),  32'd0);
    chk("rst_pulse", 32'({pkt_ok, pkt_drop, rx_zlp}), 32'd0);
    rst = 1'b1;
    tick();

    for (int r = 0; r < 10; r++) begin
      pkt_q.delete();
      for (int i = 0; i < vecs[r].len; i++) pkt_q.push_back(8'(vecs[r].base + i * vecs[r].step));
      send_pkt(vecs[r].len, vecs[r].crc, vecs[r].coinc, 1'b0);
      chk($sformatf("v%0d_ok", r),    32'(pkt_ok),   32'(vecs[r].ok));
      chk($sformatf("v%0d_drop", r),  32'(pkt_drop), 32'(vecs[r].drop));
      chk($sformatf("v%0d_zlp", r),   32'(rx_zlp),   32'(vecs[r].zlp));
      chk($sformatf("v%0d_cnt", r),   32'(pkt_cnt),  32'(vecs[r].cnt));
      chk($sformatf("v%0d_valid", r), 32'(rd_valid), 32'(vecs[r].valid));
      tick();
      chk($sformatf("v%0d_pulse_clr", r), 32'({pkt_ok, pkt_drop, rx_zlp}), 32'd0);
      if (vecs[r].drain) drain();
    end

    // Final byte with ddone while the previous packet's eop byte is popped.
    pkt_q.delete(); pkt_q.push_back(8'hC1); pkt_q.push_back(8'hC2);
    send_pkt(2, 0, 0, 0);
    pop_chk();
    pkt_q.delete(); pkt_q.push_back(8'hA1); pkt_q.push_back(8'h5A);
    rx_fifo_data = 8'hA1; rx_fifo_dvalid = 1'b1;
    tick();
    chk("co_pre_last", 32'(rd_last), 32'd1);
    rx_fifo_data = 8'h5A; rx_fifo_ddone = 1'b1; crc16_err = 1'b0; rd_en = 1'b1;
    model_ddone(2, 0);
    tick();
    rx_fifo_dvalid = 1'b0; rx_fifo_ddone = 1'b0; rd_en = 1'b0;
    mcnt--; void'(mq.pop_front());
    chk("co_ok",  32'(pkt_ok),  32'd1);
    chk("co_cnt", 32'(pkt_cnt), 32'd1);
    drain();

    // Flush mid-packet with one committed packet waiting.
    pkt_q.delete(); pkt_q.push_back(8'hD1); pkt_q.push_back(8'hD2);
    send_pkt(2, 0, 0, 0);
    chk("fl_pre_cnt", 32'(pkt_cnt), 32'd1);
    rx_fifo_dvalid = 1'b1;
    rx_fifo_data = 8'hE1; tick();
    rx_fifo_data = 8'hE2; tick();
    rx_fifo_data = 8'hE3; flush = 1'b1; tick();
    flush = 1'b0; rx_fifo_dvalid = 1'b0;
    mq.delete(); mcnt = 0;
    chk("fl_valid", 32'(rd_valid), 32'd0);
    chk("fl_cnt",   32'(pkt_cnt),  32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_pulse", 32'({pkt_ok, pkt_drop, rx_zlp}), 32'd0);
      tick();
    end
    pkt_q.delete(); pkt_q.push_back(8'hF1); pkt_q.push_back(8'hF2); pkt_q.push_back(8'hF3);
    send_pkt(3, 0, 0, 0);
    check_status("fl_next");
    drain();

    // Asynchronous reset mid-packet hides everything immediately.
    pkt_q.delete(); pkt_q.push_back(8'h31); pkt_q.push_back(8'h32); pkt_q.push_back(8'h33);
    send_pkt(3, 0, 0, 0);
    rx_fifo_dvalid = 1'b1; rx_fifo_data = 8'h41; tick();
    rx_fifo_data = 8'h42; tick();
    rx_fifo_dvalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(rd_valid), 32'd0);
    chk("ar_cnt",   32'(pkt_cnt),  32'd0);
    mq.delete(); mcnt = 0;
    #2 rst = 1'b1;
    tick();
    pkt_q.delete(); pkt_q.push_back(8'h61); pkt_q.push_back(8'h62);
    send_pkt(2, 0, 1, 0);
    check_status("ar_next");
    drain();

    for (int it = 0; it < 80; it++) begin
      int len;
      bit crc, co;
      if ($urandom_range(0, 9) < 6) begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(0, 12));
        crc = (len != 0) && ($urandom_range(0, 4) == 0);
        co  = 1'($urandom);
        pkt_q.delete();
        for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
        send_pkt(len, crc, co, 1'b1);
        check_status($sformatf("rnd%0d", it));
        tick();
        chk("rnd_pulse_clr", 32'({pkt_ok, pkt_drop, rx_zlp}), 32'd0);
      end else begin
        repeat ($urandom_range(1, 24)) pop_chk();
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
